// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared state encoding and cti constants for wb_port_arbiter
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  localparam logic [2:0] CLASSIC = 3'b000;
  localparam logic [2:0] CONST   = 3'b001;
  localparam logic [2:0] INCR    = 3'b010;
  localparam logic [2:0] EOB     = 3'b111;

endpackage

// File: rtl/wb_arb_rr_pick.sv
// rtl/wb_arb_rr_pick.sv - rotating priority encoder, searches upward from last+1
module wb_arb_rr_pick #(
  parameter int N  = 3,
  parameter int LW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  grant
);

  logic          found;
  logic [LW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = LW'((int'(last) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin Wishbone port arbiter with one idle cycle between grants
// Optional stall watchdog enabled by WB_ARB_TIMEOUT_EN.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NR_PORTS = 3,
  parameter int AW       = 30,
  parameter int DW       = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic                     wb_clk,
  input  logic                     wb_rst,
  input  logic [NR_PORTS-1:0]      wbs_cyc_i,
  input  logic [NR_PORTS-1:0]      wbs_stb_i,
  input  logic [NR_PORTS-1:0]      wbs_we_i,
  input  logic [NR_PORTS*AW-1:0]   wbs_adr_i,
  input  logic [NR_PORTS*DW-1:0]   wbs_dat_i,
  input  logic [NR_PORTS*DW/8-1:0] wbs_sel_i,
  input  logic [NR_PORTS*3-1:0]    wbs_cti_i,
  input  logic [NR_PORTS*2-1:0]    wbs_bte_i,
  output logic [DW-1:0]            wbs_dat_o,
  output logic [NR_PORTS-1:0]      wbs_ack_o,
  output logic [NR_PORTS-1:0]      wbs_err_o,
  output logic                     wbm_cyc_o,
  output logic                     wbm_stb_o,
  output logic                     wbm_we_o,
  output logic [AW-1:0]            wbm_adr_o,
  output logic [DW-1:0]            wbm_dat_o,
  output logic [DW/8-1:0]          wbm_sel_o,
  output logic [2:0]               wbm_cti_o,
  output logic [1:0]               wbm_bte_o,
  input  logic [DW-1:0]            wbm_dat_i,
  input  logic                     wbm_ack_i,
  output logic [NR_PORTS-1:0]      grant_o
);

  localparam int LW = $clog2(NR_PORTS);
  localparam int SW = DW / 8;

  arb_state_e          state_q, state_d;
  logic [NR_PORTS-1:0] grant_d, pick;
  logic [LW-1:0]       last_q, last_d, pick_idx;
  logic                release_req, timeout_hit;

  wb_arb_rr_pick #(.N(NR_PORTS), .LW(LW)) u_pick (
    .req   (wbs_cyc_i),
    .last  (last_q),
    .grant (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NR_PORTS; i++)
      if (pick[i]) pick_idx = LW'(i);
  end

  assign release_req = ~|(wbs_cyc_i & grant_o);

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic          stall;

  assign stall       = (state_q == BUSY) && wbm_stb_o && !wbm_ack_i;
  assign timeout_hit = stall && (cnt_q == CW'(TIMEOUT - 1));
  assign wbs_err_o   = grant_o & {NR_PORTS{timeout_hit}};

  // A new grant is loaded whenever a decision state sees any cyc.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst)
      cnt_q <= '0;
    else if (((state_q != BUSY) && |wbs_cyc_i) || wbm_ack_i)
      cnt_q <= '0;
    else if (stall)
      cnt_q <= cnt_q + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  assign wbs_err_o   = '0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_o;
    last_d  = last_q;
    case (state_q)
      IDLE, GAP: begin
        if (|wbs_cyc_i) begin
          grant_d = pick;
          last_d  = pick_idx;
          state_d = BUSY;
        end else begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (release_req || timeout_hit) begin
          grant_d = '0;
          state_d = GAP;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q <= IDLE;
      grant_o <= '0;
      last_q  <= LW'(NR_PORTS - 1);
    end else begin
      state_q <= state_d;
      grant_o <= grant_d;
      last_q  <= last_d;
    end
  end

  // AND-OR mux keeps every wbm_* output at zero while nothing is granted.
  always_comb begin
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_we_o  = 1'b0;
    wbm_adr_o = '0;
    wbm_dat_o = '0;
    wbm_sel_o = '0;
    wbm_cti_o = '0;
    wbm_bte_o = '0;
    for (int i = 0; i < NR_PORTS; i++) begin
      wbm_cyc_o = wbm_cyc_o | (wbs_cyc_i[i] & grant_o[i]);
      wbm_stb_o = wbm_stb_o | (wbs_stb_i[i] & grant_o[i]);
      wbm_we_o  = wbm_we_o  | (wbs_we_i[i]  & grant_o[i]);
      wbm_adr_o = wbm_adr_o | (wbs_adr_i[i*AW +: AW] & {AW{grant_o[i]}});
      wbm_dat_o = wbm_dat_o | (wbs_dat_i[i*DW +: DW] & {DW{grant_o[i]}});
      wbm_sel_o = wbm_sel_o | (wbs_sel_i[i*SW +: SW] & {SW{grant_o[i]}});
      wbm_cti_o = wbm_cti_o | (wbs_cti_i[i*3 +: 3]   & {3{grant_o[i]}});
      wbm_bte_o = wbm_bte_o | (wbs_bte_i[i*2 +: 2]   & {2{grant_o[i]}});
    end
  end

  assign wbs_ack_o = {NR_PORTS{wbm_ack_i}} & grant_o;
  assign wbs_dat_o = wbm_dat_i;

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Round-robin Wishbone arbiter that shares the single internal memory-controller port between NR_PORTS Wishbone slave ports, such as the wbs0/wbs1/wbs4 requesters of the SDRAM/DDR2 controller.
- Grants one requester at a time and holds the grant for the whole cycle (cyc high), including incrementing/wrap bursts.
- Inserts one idle cycle between grants so downstream logic always sees a cyc boundary.
- Sits between the per-port Wishbone inputs and the controller's command/FIFO front end, in the wb_clk domain.

## Interface
Parameters:
- NR_PORTS, 3, number of requesting Wishbone ports (2..8)
- AW, 30, word-address width
- DW, 32, data width
- TIMEOUT, 255, stall-cycle limit (used only with WB_ARB_TIMEOUT_EN)

Ports. One clock; reset is asynchronous and active-high.
- wb_clk  in  1  clock
- wb_rst  in  1  asynchronous active-high reset
- wbs_cyc_i  in  NR_PORTS  per-port cyc
- wbs_stb_i  in  NR_PORTS  per-port stb
- wbs_we_i  in  NR_PORTS  per-port we
- wbs_adr_i  in  NR_PORTS*AW  packed addresses; port i at [i*AW +: AW]
- wbs_dat_i  in  NR_PORTS*DW  packed write data
- wbs_sel_i  in  NR_PORTS*DW/8  packed byte selects
- wbs_cti_i  in  NR_PORTS*3  packed cti
- wbs_bte_i  in  NR_PORTS*2  packed bte
- wbs_dat_o  out  DW  read data, broadcast to all ports
- wbs_ack_o  out  NR_PORTS  per-port ack
- wbs_err_o  out  NR_PORTS  per-port err
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  muxed to controller
- wbm_adr_o  out  AW  muxed to controller
- wbm_dat_o  out  DW  muxed to controller
- wbm_sel_o  out  DW/8  muxed to controller
- wbm_cti_o  out  3  muxed to controller
- wbm_bte_o  out  2  muxed to controller
- wbm_dat_i  in  DW  read data from controller
- wbm_ack_i  in  1  ack from controller
- grant_o  out  NR_PORTS  registered one-hot grant

## Operation
States:
- IDLE: grant_o=0. If any wbs_cyc_i is high, load grant_o with the round-robin winner and go to BUSY.
- BUSY: hold the grant. When the granted port's cyc is sampled low, clear grant_o and go to GAP.
- GAP: grant_o=0 for exactly one cycle.
  - If any cyc is high, load the new winner and go to BUSY.
  - Otherwise go to IDLE.

Round robin:
- last_q holds the index of the most recently granted port.
- The winner is the first requesting port searching from last_q+1 upward, wrapping modulo NR_PORTS.
- Reset value of last_q is NR_PORTS-1, so port 0 wins first.

Datapath muxing:
- All wbm_* outputs are a combinational AND-OR mux of the granted port's inputs, gated by grant_o. All wbm_* outputs are 0 when nothing is granted.
- wbs_ack_o[i] = wbm_ack_i & grant_o[i].
- wbs_dat_o = wbm_dat_i, unregistered.

Other rules:
- A port that drops cyc without ever being acked is legal; the arbiter releases it normally.
- A request from an ungranted port is ignored until a grant decision point (IDLE or GAP).

## Timing
- Reset (asynchronous, immediate): grant_o=0, all wbm_* outputs=0, wbs_ack_o=0, wbs_err_o=0, state=IDLE, last_q=NR_PORTS-1, timeout counter=0.
- Grant latency: cyc first sampled high at edge n gives grant_o and wbm_cyc_o high after edge n (one cycle).
- Release: granted cyc sampled low at edge m gives grant_o=0 after m. The next grant appears after m+1.
- Ack path has zero latency, combinational from wbm_ack_i.
- Reset asserted mid-burst: the transaction is abandoned and wbm_cyc_o drops immediately. After deassertion, arbitration restarts from port 0.

## Configuration
WB_ARB_TIMEOUT_EN enables a stall watchdog.

When WB_ARB_TIMEOUT_EN is defined:
- A counter clears on every grant and on every wbm_ack_i.
- It increments each BUSY cycle with wbm_stb_o high and wbm_ack_i low.
- When it reaches TIMEOUT, wbs_err_o of the granted port pulses for one cycle and the state is forced to GAP, dropping wbm_cyc_o.
- If that port still holds cyc high, it is treated as a fresh requester.

When WB_ARB_TIMEOUT_EN is undefined:
- No counter is built.
- wbs_err_o is tied to 0.
- A stalled master holds the grant indefinitely.

## Structure
- Shared package wb_arb_pkg contains:
  - the state encoding: IDLE=2'd0, BUSY=2'd1, GAP=2'd2;
  - the cti constants: CLASSIC=3'b000, CONST=3'b001, INCR=3'b010, EOB=3'b111.
- One sub-module, wb_arb_rr_pick: a combinational rotating priority encoder with inputs (req, last) and output one-hot grant.

## Test plan
- Single request: port 1 classic write of adr=0x100, dat=0xDEADBEEF at cycle 0 → grant_o=3'b010 at cycle 1, wbm_adr_o=0x100, and ack goes only to wbs_ack_o[1].
- All three ports request from reset → grant order 001, 010, 100, with exactly one grant_o=0 cycle between grants.
- Burst hold: port 0 runs a 4-beat INCR burst (cti 010,010,010,111) while port 2 requests during beat 2 → grant stays 001 until port 0's cyc drops; port 2 is granted 2 cycles later.
- Fairness: port 0 re-asserts cyc immediately after release while port 1 is waiting → port 1 is granted before port 0's second grant.
- Reset mid-burst: wb_rst pulses during port 1's burst → all outputs read 0 within the same cycle; after release, a fresh request from port 1 alone is granted after 1 cycle.
- Watchdog (WB_ARB_TIMEOUT_EN defined, TIMEOUT=8): granted port 0 asserts stb and wbm_ack_i is held low → wbs_err_o[0] pulses on the 8th stall cycle, wbm_cyc_o drops, and waiting port 1 is granted after the GAP cycle. With the macro undefined, the grant holds for 100 cycles and err stays 0.
